branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, SHALL give the number of pattern-history entries and SHALL be a power of two, 2..256.
REQ-002 Parameter IDX_W, default 4, SHALL equal log2(ENTRIES).
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_is_branch  input  1  the fetch-stage instruction is a conditional branch.
REQ-006 if_pc  input  32  fetch-stage PC.
REQ-007 if_target  input  32  fetch-stage branch target.
REQ-008 pred_taken  output  1  prediction for the fetch-stage branch.
REQ-009 pred_pc  output  32  next fetch PC.
REQ-010 ex_valid  input  1  a conditional branch resolves in EX this cycle.
REQ-011 ex_pc  input  32  PC of the resolving branch.
REQ-012 ex_target  input  32  resolved branch target.
REQ-013 ex_taken  input  1  actual branch outcome.
REQ-014 ex_pred_taken  input  1  prediction made for that branch, carried down the pipe.
REQ-015 redirect  output  1  registered mispredict flush request.
REQ-016 redirect_pc  output  32  registered correct fetch PC.
REQ-017 stat_branches  output  16  count of resolved branches.
REQ-018 stat_mispredicts  output  16  count of mispredicted branches.

Function
REQ-019 The block SHALL hold ENTRIES 2-bit counters (PHT); the index SHALL be pc[IDX_W+1:2].
REQ-020 The counter states SHALL be 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken and 11 strong-taken; the prediction SHALL be counter bit 1.
REQ-021 pred_taken SHALL be combinational: if_is_branch AND PHT[idx(if_pc)][1].
REQ-022 pred_pc SHALL be if_target when pred_taken=1, else if_pc+4 (32-bit wrap, carry dropped).
REQ-023 On ex_valid=1 the PHT[idx(ex_pc)] update at the clock edge SHALL be: ex_taken=1 increments, saturating at 11; ex_taken=0 decrements, saturating at 00.
REQ-024 With ex_valid=0, no PHT entry SHALL change.
REQ-025 Same-cycle read and write to the same index: pred_taken SHALL use the pre-update value (no bypass).
REQ-026 Mispredict SHALL be defined as ex_valid AND (ex_taken != ex_pred_taken).
REQ-027 redirect SHALL be asserted the cycle after a mispredict, for exactly one cycle.
REQ-028 redirect_pc SHALL be ex_target when ex_taken=1, else ex_pc+4, captured on the same edge as redirect; it SHALL hold its value while redirect=0.
REQ-029 Back-to-back mispredicts SHALL keep redirect high, with redirect_pc updated each cycle.
REQ-030 stat_branches SHALL increment by 1 per ex_valid cycle and saturate at 16'hFFFF.
REQ-031 stat_mispredicts SHALL increment by 1 per mispredict and saturate at 16'hFFFF.
REQ-032 The block SHALL assume nothing about ex_pc aliasing; distinct PCs with the same index SHALL share one counter.

Reset
REQ-033 With rst=1 at a clock edge: all PHT entries SHALL become 00; redirect SHALL become 0; redirect_pc SHALL become 0; both stat counters SHALL become 0.
REQ-034 rst SHALL take priority over a simultaneous ex_valid; no update or count SHALL occur that cycle.
REQ-035 After reset, pred_taken SHALL be 0 for every PC, and pred_pc SHALL equal if_pc+4.

Verification
REQ-036 Reset, then if_is_branch=1, if_pc=0x100, if_target=0x200 -> pred_taken=0, pred_pc=0x104.
REQ-037 Two ex_valid cycles, each with ex_pc=0x100, ex_taken=1, ex_pred_taken=0 -> PHT[0] goes 00->01->10; pred_taken=1 and pred_pc=0x200 for if_pc=0x100; redirect high for 2 cycles; stat_mispredicts=2.
REQ-038 Five taken updates to ex_pc=0x104, followed by one not-taken update -> counter saturates at 11, then drops to 10; pred_taken stays 1.
REQ-039 ex_valid with ex_pc=0x1C, ex_taken=0, ex_pred_taken=1 -> next cycle redirect=1 and redirect_pc=0x20; the following cycle redirect=0 and redirect_pc holds 0x20.
REQ-040 Same cycle: if_pc=ex_pc=0x100, counter at 01, ex_taken=1 -> pred_taken=0 that cycle and 1 the next cycle.
REQ-041 Force stat_branches to 0xFFFF via 65535 updates, then apply one more -> the value stays 0xFFFF; assert rst mid-stream together with ex_valid -> all counters read 0 and no increment occurs.

Source files
------------

// File: rtl/branch_predictor.sv
// Bimodal branch predictor built on a table of 2-bit saturating counters.
// It also registers a mispredict redirect and keeps saturating branch statistics.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_is_branch,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_target,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispredicts
);

    logic [1:0]       pht [ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ex_ctr;
    logic             mispredict;

    assign if_idx     = if_pc[IDX_W+1:2];
    assign ex_idx     = ex_pc[IDX_W+1:2];
    assign ex_ctr     = pht[ex_idx];
    assign mispredict = ex_valid & (ex_taken != ex_pred_taken);

    // The fetch-side read sees the table before this cycle's update is written.
    assign pred_taken = if_is_branch & pht[if_idx][1];
    assign pred_pc    = pred_taken ? if_target : if_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= 2'b00;
            end
            redirect         <= 1'b0;
            redirect_pc      <= 32'd0;
            stat_branches    <= 16'd0;
            stat_mispredicts <= 16'd0;
        end else begin
            redirect <= mispredict;
            if (mispredict) begin
                redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
            end
            if (ex_valid) begin
                if (ex_taken && ex_ctr != 2'b11) begin
                    pht[ex_idx] <= ex_ctr + 2'd1;
                end else if (!ex_taken && ex_ctr != 2'b00) begin
                    pht[ex_idx] <= ex_ctr - 2'd1;
                end
                if (stat_branches != 16'hFFFF) begin
                    stat_branches <= stat_branches + 16'd1;
                end
            end
            if (mispredict && stat_mispredicts != 16'hFFFF) begin
                stat_mispredicts <= stat_mispredicts + 16'd1;
            end
        end
    end

endmodule
